// File: rtl/mdl_abspgcntr.sv
// Absolute page counter and seek sequencer for the bubble shift front end.
// Tracks loop position one page per rotation, seeks to a target page and sequences start/stop.
module mdl_abspgcntr #(
    parameter int unsigned PAGE_MAX = 2052
) (
    input  logic        i_MCLK,
    input  logic        i_SYS_RST_n,
    input  logic        i_CLK2M_PCEN_n,
    input  logic [19:0] i_ROT20_n,
    input  logic        i_BSEN_n,
    input  logic        i_CMD_START,
    input  logic        i_CMD_ABORT,
    input  logic [11:0] i_TARGET_PG,
    output logic        o_ABSPGCNTR_CNT_START,
    output logic        o_ABSPGCNTR_CNT_STOP,
    output logic        o_VALPG_ACC_FLAG,
    output logic [11:0] o_ABSPG,
    output logic        o_BUSY,
    output logic        o_PGERR
);

    localparam logic [11:0] PgMax = 12'(PAGE_MAX);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StArm    = 3'd1;
    localparam logic [2:0] StStart  = 3'd2;
    localparam logic [2:0] StSeek   = 3'd3;
    localparam logic [2:0] StAccess = 3'd4;
    localparam logic [2:0] StStop   = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [11:0] abspg_q, abspg_d;
    logic [11:0] target_q, target_d;
    logic        cnt_start_q, cnt_start_d;
    logic        cnt_stop_q, cnt_stop_d;
    logic        valpg_q, valpg_d;
    logic        busy_q, busy_d;
    logic        pgerr_q, pgerr_d;

    logic        tick;
    logic        eor;
    logic        counting;
    logic [11:0] pg_next;

    assign tick     = ~i_CLK2M_PCEN_n;
    assign eor      = tick & ~i_ROT20_n[19];
    assign counting = eor & ~i_BSEN_n &
                      ((state_q == StStart) | (state_q == StSeek) |
                       (state_q == StAccess) | (state_q == StStop));
    assign pg_next  = (abspg_q == PgMax) ? 12'd0 : abspg_q + 12'd1;

    always_comb begin
        state_d     = state_q;
        abspg_d     = abspg_q;
        target_d    = target_q;
        cnt_start_d = cnt_start_q;
        cnt_stop_d  = cnt_stop_q;
        valpg_d     = valpg_q;
        busy_d      = busy_q;
        pgerr_d     = pgerr_q;

        // Page tracking runs independently of sequencing, including on an abort tick.
        if (counting) begin
            abspg_d = pg_next;
        end

        if (tick) begin
            case (state_q)
                StIdle: begin
                    if (i_CMD_START) begin
                        if (i_TARGET_PG <= PgMax) begin
                            target_d = i_TARGET_PG;
                            pgerr_d  = 1'b0;
                            busy_d   = 1'b1;
                            state_d  = StArm;
                        end else begin
                            pgerr_d = 1'b1;
                        end
                    end
                end
                StArm: begin
                    if (i_CMD_ABORT) begin
                        busy_d  = 1'b0;
                        state_d = StIdle;
                    end else if (eor) begin
                        cnt_start_d = 1'b1;
                        state_d     = StStart;
                    end
                end
                StStart, StSeek, StAccess: begin
                    if (i_CMD_ABORT) begin
                        cnt_start_d = 1'b0;
                        valpg_d     = 1'b0;
                        cnt_stop_d  = 1'b1;
                        state_d     = StStop;
                    end else if (state_q == StStart) begin
                        if (eor) begin
                            cnt_start_d = 1'b0;
                            state_d     = StSeek;
                        end
                    end else if (state_q == StSeek) begin
                        // Compare against the page being entered, so the current page needs a full loop.
                        if (counting && (pg_next == target_q)) begin
                            valpg_d = 1'b1;
                            state_d = StAccess;
                        end
                    end else if (eor) begin
                        valpg_d    = 1'b0;
                        cnt_stop_d = 1'b1;
                        state_d    = StStop;
                    end
                end
                StStop: begin
                    if (i_BSEN_n) begin
                        cnt_stop_d = 1'b0;
                        busy_d     = 1'b0;
                        state_d    = StIdle;
                    end
                end
                default: begin
                    cnt_start_d = 1'b0;
                    cnt_stop_d  = 1'b0;
                    valpg_d     = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge i_MCLK or negedge i_SYS_RST_n) begin
        if (!i_SYS_RST_n) begin
            state_q     <= StIdle;
            abspg_q     <= 12'd0;
            target_q    <= 12'd0;
            cnt_start_q <= 1'b0;
            cnt_stop_q  <= 1'b0;
            valpg_q     <= 1'b0;
            busy_q      <= 1'b0;
            pgerr_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            abspg_q     <= abspg_d;
            target_q    <= target_d;
            cnt_start_q <= cnt_start_d;
            cnt_stop_q  <= cnt_stop_d;
            valpg_q     <= valpg_d;
            busy_q      <= busy_d;
            pgerr_q     <= pgerr_d;
        end
    end

    assign o_ABSPGCNTR_CNT_START = cnt_start_q;
    assign o_ABSPGCNTR_CNT_STOP  = cnt_stop_q;
    assign o_VALPG_ACC_FLAG      = valpg_q;
    assign o_ABSPG               = abspg_q;
    assign o_BUSY                = busy_q;
    assign o_PGERR               = pgerr_q;

endmodule

// File: tb/tb_mdl_abspgcntr.sv
// Randomized bench for mdl_abspgcntr with a small page loop, a front-end model and a scoreboard.
module tb_mdl_abspgcntr;

    localparam int unsigned PgMax = 7;
    localparam int          N     = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pcen_n = 1'b1;
    logic [19:0] rot_n = '1;
    logic        bsen_n = 1'b1;
    logic        cmd_start = 1'b0;
    logic        cmd_abort = 1'b0;
    logic [11:0] target = 12'd0;

    logic        o_cnt_start, o_cnt_stop, o_valpg, o_busy, o_pgerr;
    logic [11:0] o_abspg;

    always #5 clk = ~clk;

    mdl_abspgcntr #(.PAGE_MAX(PgMax)) dut (
        .i_MCLK               (clk),
        .i_SYS_RST_n          (rst_n),
        .i_CLK2M_PCEN_n       (pcen_n),
        .i_ROT20_n            (rot_n),
        .i_BSEN_n             (bsen_n),
        .i_CMD_START          (cmd_start),
        .i_CMD_ABORT          (cmd_abort),
        .i_TARGET_PG          (target),
        .o_ABSPGCNTR_CNT_START(o_cnt_start),
        .o_ABSPGCNTR_CNT_STOP (o_cnt_stop),
        .o_VALPG_ACC_FLAG     (o_valpg),
        .o_ABSPG              (o_abspg),
        .o_BUSY               (o_busy),
        .o_PGERR              (o_pgerr)
    );

    typedef struct {
        bit          abort_op;
        int unsigned tgt;
        int unsigned k;
    } item_t;

    item_t sb[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // What the last clock edge saw on the inputs, and the reference page position.
    logic        p_slot, p_cnt;
    int unsigned ref_pg;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_slot <= 1'b0;
            p_cnt  <= 1'b0;
            ref_pg <= 0;
        end else begin
            p_slot <= !pcen_n && (rot_n != '1);
            p_cnt  <= !pcen_n && !rot_n[19] && !bsen_n;
            if (!pcen_n && !rot_n[19] && !bsen_n) ref_pg <= (ref_pg + 1) % N;
        end
    end

    bit s_prev, v_prev, stp_prev, b_prev, saw_v;
    int s_slots, v_slots, m_cnt, match_pg, match_cnt;

    initial begin : monitor
        item_t it;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                s_prev = 0; v_prev = 0; stp_prev = 0; b_prev = 0; saw_v = 0;
                s_slots = 0; v_slots = 0; m_cnt = 0;
            end else begin
                if (p_cnt) begin
                    m_cnt++;
                    check("abspg", int'(o_abspg), int'(ref_pg));
                end
                if (o_busy && !b_prev) begin
                    m_cnt = 0;
                    saw_v = 0;
                end
                if (s_prev && p_slot) s_slots++;
                if (s_prev && !o_cnt_start) begin
                    check("cnt_start_slots", s_slots, 20);
                    s_slots = 0;
                end
                if (v_prev && p_slot) v_slots++;
                if (o_valpg && !v_prev) begin
                    saw_v     = 1;
                    match_pg  = int'(o_abspg);
                    match_cnt = m_cnt;
                end
                if (v_prev && !o_valpg) begin
                    check("valpg_slots", v_slots, 20);
                    v_slots = 0;
                end
                if (o_cnt_stop && !stp_prev) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_stop: got stop with empty queue at %0t", $time);
                    end else begin
                        it = sb.pop_front();
                        if (it.abort_op) begin
                            check("abort_no_valpg", int'(saw_v), 0);
                        end else begin
                            check("valpg_seen", int'(saw_v), 1);
                            check("match_page", match_pg, int'(it.tgt));
                            check("match_counts", match_cnt, int'(it.k));
                        end
                    end
                end
                s_prev = o_cnt_start; v_prev = o_valpg; stp_prev = o_cnt_stop; b_prev = o_busy;
            end
        end
    end

    // Stimulus: rotation generator plus a front end that enables shifting on start, stops on request.
    int cur_slot = 0;
    int hold = 0;
    int stop_eors = 0;
    bit stop_seen = 0;

    task automatic cyc(input bit force_tick, input bit start, input logic [11:0] tgt, input bit abort);
        bit tk, gap, eor_done;
        tk  = force_tick || ($urandom_range(3) != 0);
        gap = !force_tick && ($urandom_range(15) == 0);
        pcen_n    = !tk;
        cmd_start = start;
        cmd_abort = abort;
        target    = tgt;
        rot_n     = '1;
        if (!gap) rot_n[cur_slot] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        eor_done = tk && !gap && (cur_slot == 19);
        if (tk && !gap) cur_slot = (cur_slot == 19) ? 0 : cur_slot + 1;
        cmd_start = 1'b0;
        cmd_abort = 1'b0;
        if (o_cnt_stop) begin
            if (eor_done && stop_seen) stop_eors++;
            stop_seen = 1;
            if (stop_eors >= hold) bsen_n = 1'b1;
        end else begin
            stop_seen = 0;
            stop_eors = 0;
            if (o_cnt_start) bsen_n = 1'b0;
        end
    endtask

    function automatic int unsigned counts_to_match(input int unsigned tgt, input int unsigned from);
        int d;
        d = int'(tgt) - int'(from) - 2;
        d = ((d % N) + N) % N;
        return d + 2;
    endfunction

    task automatic issue(input logic [11:0] tgt, input int h, input bit abort_at_match);
        item_t it;
        hold        = h;
        it.abort_op = abort_at_match;
        it.tgt      = tgt;
        it.k        = counts_to_match(tgt, ref_pg);
        sb.push_back(it);
        cyc(1, 1, tgt, 0);
        check("busy_after_cmd", int'(o_busy), 1);
        check("pgerr_after_cmd", int'(o_pgerr), 0);
    endtask

    task automatic finish_op(input int unsigned k, input bit abort_at_match, input bit noise);
        int guard;
        guard = 0;
        while (o_busy && guard < 4000) begin
            if (abort_at_match && m_cnt == int'(k) - 1 && cur_slot == 19 && !bsen_n && !o_cnt_start)
                cyc(1, 0, 12'd0, 1);
            else
                cyc(0, noise && ($urandom_range(7) == 0), 12'($urandom_range(PgMax)), 0);
            guard++;
        end
        if (guard >= 4000) begin
            total++;
            bad++;
            $display("FAIL op_timeout: busy still %0d after %0d cycles", o_busy, guard);
        end
    endtask

    task automatic do_op(input logic [11:0] tgt, input int h, input bit abort_at_match,
                         input bit noise);
        int unsigned k;
        k = counts_to_match(tgt, ref_pg);
        issue(tgt, h, abort_at_match);
        finish_op(k, abort_at_match, noise);
    endtask

    initial begin : driver
        bit flag;
        int unsigned k;
        int guard;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cnt_start", int'(o_cnt_start), 0);
        check("rst_cnt_stop", int'(o_cnt_stop), 0);
        check("rst_valpg", int'(o_valpg), 0);
        check("rst_abspg", int'(o_abspg), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_pgerr", int'(o_pgerr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) cyc(0, 0, 12'd0, 0);

        do_op(12'd3, 0, 0, 0);
        do_op(12'(ref_pg), 1, 0, 0);
        do_op(12'((ref_pg + 3) % N), 2, 0, 1);
        do_op(12'((ref_pg + 4) % N), 3, 1, 0);
        for (int i = 0; i < 8; i++) begin
            do_op(12'($urandom_range(PgMax)), int'($urandom_range(3)), ($urandom_range(3) == 0),
                  ($urandom_range(1) == 1));
            repeat ($urandom_range(5)) cyc(0, 0, 12'd0, 0);
        end

        // Out-of-range targets are rejected and leave the sequencer idle.
        cyc(1, 1, 12'd8, 0);
        check("pgerr_set", int'(o_pgerr), 1);
        check("pgerr_not_busy", int'(o_busy), 0);
        flag = 0;
        for (int i = 0; i < 60; i++) begin
            cyc(0, (i == 10), 12'd4095, 0);
            if (o_busy || o_cnt_start) flag = 1;
        end
        check("pgerr_stays_idle", int'(flag), 0);
        check("pgerr_sticky", int'(o_pgerr), 1);
        do_op(12'd7, 0, 0, 0);

        // Abort while armed returns straight to idle without a start request.
        cyc(1, 1, 12'd2, 0);
        check("arm_busy", int'(o_busy), 1);
        cyc(1, 0, 12'd0, 1);
        check("arm_abort_idle", int'(o_busy), 0);
        flag = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(0, 0, 12'd0, 0);
            if (o_busy || o_cnt_start) flag = 1;
        end
        check("arm_abort_quiet", int'(flag), 0);

        // Asynchronous reset in the middle of a seek.
        k = counts_to_match(12'((ref_pg + 1) % N), ref_pg);
        issue(12'((ref_pg + 1) % N), 0, 0);
        guard = 0;
        while (!(m_cnt >= 2 && !o_cnt_start && o_busy && !o_valpg) && guard < 2000) begin
            cyc(0, 0, 12'd0, 0);
            guard++;
        end
        check("seek_reached", int'(guard < 2000), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_cnt_start", int'(o_cnt_start), 0);
        check("async_cnt_stop", int'(o_cnt_stop), 0);
        check("async_valpg", int'(o_valpg), 0);
        check("async_abspg", int'(o_abspg), 0);
        check("async_busy", int'(o_busy), 0);
        sb.delete();
        bsen_n    = 1'b1;
        stop_seen = 0;
        stop_eors = 0;
        #1;
        rst_n = 1'b1;
        repeat (4) cyc(0, 0, 12'd0, 0);
        check("post_rst_abspg", int'(o_abspg), 0);
        check("post_rst_busy", int'(o_busy), 0);
        do_op(12'd5, 1, 0, 1);

        repeat (4) cyc(0, 0, 12'd0, 0);
        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
